// File: rtl/riscv_decode_issue.sv
// riscv_decode_issue
//   RV32I decode/issue stage. Decodes one fetched instruction per cycle and
//   holds the decoded fields for the execute stage (alu) in an output register
//   backed by one skid entry. Order is preserved and nothing is dropped under
//   backpressure.
//
// Optional feature macro: DEC_ILLEGAL_CHK_EN
//   defined   -> dec_illegal flags malformed/unsupported encodings
//   undefined -> dec_illegal tied to 0, no check logic
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   flush                  synchronous kill of both buffered entries
//   in_valid/in_ready      input handshake; in_instr, in_pc payload
//   out_valid/out_ready    output handshake toward execute
//   out_pc                 pc of the decoded instruction
//   alu_opcode/ir30/func3  alu control fields
//   rs1_addr/rs2_addr/rd_addr  register addresses (rd=0 for STORE/BRANCH)
//   imm, use_imm           immediate and alu in2 select
//   dec_illegal            illegal-instruction flag
module riscv_decode_issue #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [6:0]       alu_opcode,
  output logic             alu_ir30,
  output logic [2:0]       alu_func3,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic [WIDTH-1:0] imm,
  output logic             use_imm,
  output logic             dec_illegal
);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [6:0]       opcode;
    logic             ir30;
    logic [2:0]       func3;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [WIDTH-1:0] imm;
    logic             use_imm;
    logic             illegal;
  } dec_t;

  function automatic logic is_shift_imm(input logic [31:0] i);
    return (i[6:0] == OPC_OPIMM) && (i[13:12] == 2'b01);
  endfunction

  // 32-bit immediate, sign-extended to WIDTH from bit 31 afterwards.
  // Shift-imm keeps bit 31 clear so the extension is a zero-extension.
  function automatic logic signed [WIDTH-1:0] imm_dec(input logic [31:0] i);
    logic signed [31:0] v;
    v = '0;
    case (i[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        if (is_shift_imm(i)) v = {27'b0, i[24:20]};
        else                 v = {{20{i[31]}}, i[31:20]};
      end
      OPC_STORE:         v = {{20{i[31]}}, i[31:25], i[11:7]};
      OPC_BRANCH:        v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: v = {i[31:12], 12'b0};
      OPC_JAL:           v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:           v = '0;
    endcase
    return WIDTH'(v);
  endfunction

`ifdef DEC_ILLEGAL_CHK_EN
  function automatic logic illegal_dec(input logic [31:0] i);
    logic bad;
    bad = (i[1:0] != 2'b11);
    case (i[6:0])
      OPC_OPIMM: begin
        if (is_shift_imm(i) && (i[31:25] != 7'b0000000) && (i[31:25] != 7'b0100000))
          bad = 1'b1;
      end
      OPC_OP: begin
        if ((i[31:25] != 7'b0000000) && (i[31:25] != 7'b0100000))
          bad = 1'b1;
        else if ((i[31:25] == 7'b0100000) && (i[14:12] != 3'b000) && (i[14:12] != 3'b101))
          bad = 1'b1;
      end
      OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH,
      OPC_LUI, OPC_AUIPC, OPC_JAL: ;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction
`endif

  // Stage p0: combinational decode of the incoming instruction
  dec_t dec_p0;
  always_comb begin
    dec_p0         = '0;
    dec_p0.pc      = in_pc;
    dec_p0.opcode  = in_instr[6:0];
    dec_p0.func3   = in_instr[14:12];
    dec_p0.rs1     = in_instr[19:15];
    dec_p0.rs2     = in_instr[24:20];
    dec_p0.rd      = ((in_instr[6:0] == OPC_STORE) || (in_instr[6:0] == OPC_BRANCH))
                     ? 5'd0 : in_instr[11:7];
    // ir30 only selects SUB/SRA/SRAI; gating it keeps ADDI and friends from subtracting.
    dec_p0.ir30    = in_instr[30] & ((in_instr[6:0] == OPC_OP) ||
                     ((in_instr[6:0] == OPC_OPIMM) && (in_instr[14:12] == 3'b101)));
    dec_p0.imm     = imm_dec(in_instr);
    dec_p0.use_imm = !((in_instr[6:0] == OPC_OP) || (in_instr[6:0] == OPC_BRANCH));
`ifdef DEC_ILLEGAL_CHK_EN
    dec_p0.illegal = illegal_dec(in_instr);
`else
    dec_p0.illegal = 1'b0;
`endif
  end

  // Stage p1: output register plus skid entry
  dec_t out_p1;
  dec_t skid_p1;
  logic vld_p1;
  logic skid_vld_p1;
  logic acc;
  logic out_free;

  assign in_ready = !skid_vld_p1;
  assign acc      = in_valid && !skid_vld_p1;
  assign out_free = !vld_p1 || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_p1      <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (out_free) begin
      // skid is always older than anything arriving now; while skid is full
      // in_ready is low, so acc cannot coincide with this move.
      if (skid_vld_p1) begin
        out_p1      <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else if (acc) begin
        out_p1 <= dec_p0;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (acc) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!out_free && acc && !flush)
      skid_p1 <= dec_p0;
  end

  assign out_valid   = vld_p1;
  assign out_pc      = out_p1.pc;
  assign alu_opcode  = out_p1.opcode;
  assign alu_ir30    = out_p1.ir30;
  assign alu_func3   = out_p1.func3;
  assign rs1_addr    = out_p1.rs1;
  assign rs2_addr    = out_p1.rs2;
  assign rd_addr     = out_p1.rd;
  assign imm         = out_p1.imm;
  assign use_imm     = out_p1.use_imm;
  assign dec_illegal = out_p1.illegal;

endmodule

// File: tb/tb_riscv_decode_issue.sv
// Directed bench for riscv_decode_issue: decode of representative RV32I
// encodings, skid buffering under backpressure, flush and async reset.
module tb_riscv_decode_issue;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [WIDTH-1:0] in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [6:0]       alu_opcode;
  logic             alu_ir30;
  logic [2:0]       alu_func3;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [4:0]       rd_addr;
  logic [WIDTH-1:0] imm;
  logic             use_imm;
  logic             dec_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  riscv_decode_issue #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_opcode(alu_opcode), .alu_ir30(alu_ir30), .alu_func3(alu_func3),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .imm(imm), .use_imm(use_imm), .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [WIDTH-1:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imm", imm, 0);
    chk("rst_pc", out_pc, 0);
    step(); step();
    rst_n = 1'b1;
    out_ready = 1'b1;

    // ADDI x1,x0,5
    send(32'h00500093, 32'h100);
    chk("addi_valid", out_valid, 1);
    chk("addi_opcode", alu_opcode, 7'b0010011);
    chk("addi_func3", alu_func3, 0);
    chk("addi_ir30", alu_ir30, 0);
    chk("addi_rd", rd_addr, 1);
    chk("addi_rs1", rs1_addr, 0);
    chk("addi_imm", imm, 5);
    chk("addi_use_imm", use_imm, 1);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_illegal", dec_illegal, 0);

    // SUB x3,x1,x2
    send(32'h402081B3, 32'h104);
    chk("sub_ir30", alu_ir30, 1);
    chk("sub_func3", alu_func3, 0);
    chk("sub_rd", rd_addr, 3);
    chk("sub_rs1", rs1_addr, 1);
    chk("sub_rs2", rs2_addr, 2);
    chk("sub_use_imm", use_imm, 0);
    chk("sub_imm", imm, 0);

    // SRAI x5,x5,3
    send(32'h4032D293, 32'h108);
    chk("srai_ir30", alu_ir30, 1);
    chk("srai_func3", alu_func3, 5);
    chk("srai_imm", imm, 3);

    // ADDI x1,x0,-1 : bit30 set but must not reach ir30
    send(32'hFFF00093, 32'h10C);
    chk("addim1_imm", imm, 32'hFFFFFFFF);
    chk("addim1_ir30", alu_ir30, 0);

    // SW x1,4(x2)
    send(32'h00112223, 32'h110);
    chk("sw_imm", imm, 4);
    chk("sw_rd", rd_addr, 0);
    chk("sw_use_imm", use_imm, 1);

    // BEQ x0,x0,-4
    send(32'hFE000EE3, 32'h114);
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_rd", rd_addr, 0);
    chk("beq_use_imm", use_imm, 0);

    // LUI x1,0x12345
    send(32'h123450B7, 32'h118);
    chk("lui_imm", imm, 32'h12345000);

    // JAL x1,8
    send(32'h008000EF, 32'h11C);
    chk("jal_imm", imm, 8);
    chk("jal_rd", rd_addr, 1);

    step();
    chk("drain_empty", out_valid, 0);

    // Backpressure: pc 0,4,8 offered while execute stalls
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0;
    chk("bp_ready0", in_ready, 1);
    step();
    chk("bp_pc0", out_pc, 0);
    chk("bp_ready1", in_ready, 1);
    in_pc = 32'h4;
    step();
    chk("bp_ready2", in_ready, 0);
    chk("bp_hold_pc", out_pc, 0);
    in_pc = 32'h8;
    step();
    chk("bp_ready3", in_ready, 0);
    chk("bp_hold_pc2", out_pc, 0);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("bp_out4", out_pc, 4);
    chk("bp_out4_valid", out_valid, 1);
    chk("bp_ready4", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_out8", out_pc, 8);
    chk("bp_out8_valid", out_valid, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // Flush with two entries buffered
    out_ready = 1'b0;
    send(32'h00500093, 32'h20);
    send(32'h00500093, 32'h24);
    chk("fl_full", in_ready, 0);
    chk("fl_valid", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h28;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_valid_after", out_valid, 0);
    chk("fl_ready_after", in_ready, 1);
    step();
    chk("fl_no_emit", out_valid, 0);

    // Flush discards an instruction accepted in the same cycle
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h30;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_acc_discard", out_valid, 0);

    // All-zero encoding still flows; flag depends on build
    send(32'h00000000, 32'h40);
    chk("ill_valid", out_valid, 1);
`ifdef DEC_ILLEGAL_CHK_EN
    chk("ill_flag", dec_illegal, 1);
`else
    chk("ill_flag", dec_illegal, 0);
`endif
    step();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    send(32'hFFF00093, 32'h50);
    chk("mr_loaded", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_imm", imm, 0);
    chk("mr_ready", in_ready, 1);
    step();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
